prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader_if.sv | 20 ++
 rtl/prog_loader_word_packer.sv | 36 +++
 rtl/prog_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states and word geometry.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FULL,
    DONE
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory-write bus of the program loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;

  modport master (
    input  in_valid, in_data, mem_gnt,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_gnt,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles little-endian bytes into a 32-bit word, lane 0 first.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_wr,
  input  logic [7:0]        i_byte,
  output logic [31:0]       o_word,
  output logic [LANE_W-1:0] o_lane,
  output logic              o_full
);

  logic [31:0]       r_word;
  logic [LANE_W-1:0] r_lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_wr) begin
      r_word[{r_lane, 3'b000} +: 8] <= i_byte;
      r_lane                        <= r_lane + 1'b1;
    end
  end

  assign o_word = r_word;
  assign o_lane = r_lane;
  // Lane index wraps to 0 as the last byte lands, so "full" is the write itself.
  assign o_full = i_wr && (r_lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into program memory one word at a time, holding the CPU off.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                load_end,
  prog_loader_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [31:0]         word_count
);

  state_t            r_state, w_next;
  logic [31:0]       r_word_idx;
  logic              r_overflow;
  logic              r_end_pend;

  logic              w_start, w_clear, w_pack_wr, w_full, w_inc, w_set_ovf, w_set_pend;
  logic [31:0]       w_word;
  logic [LANE_W-1:0] w_lane;

  word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_wr    (w_pack_wr),
    .i_byte  (bus.in_data),
    .o_word  (w_word),
    .o_lane  (w_lane),
    .o_full  (w_full)
  );

  always_comb begin
    w_next        = r_state;
    w_start       = 1'b0;
    w_clear       = 1'b0;
    w_pack_wr     = 1'b0;
    w_inc         = 1'b0;
    w_set_ovf     = 1'b0;
    w_set_pend    = 1'b0;
    done          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start = 1'b1;
          w_clear = 1'b1;
          w_next  = COLLECT;
        end
      end
      COLLECT: begin
        bus.in_ready = 1'b1;
        w_pack_wr    = bus.in_valid;
        // A completed word always goes out first, even when the stream ends with it.
        if (w_full) begin
          w_next     = WRITE;
          w_set_pend = load_end;
        end else if (load_end) begin
          if (w_lane == '0 && !bus.in_valid) begin
            w_next = DONE;
          end else begin
            w_set_pend = 1'b1;
            w_next     = WRITE;
          end
        end
      end
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {r_word_idx[29:0], 2'b00};
        bus.mem_wdata = w_word;
        w_set_pend    = load_end;
        if (bus.mem_gnt) begin
          w_inc   = 1'b1;
          w_clear = 1'b1;
          if (r_end_pend || load_end)                    w_next = DONE;
          else if (r_word_idx == 32'(MEM_WORDS - 1))     w_next = FULL;
          else                                           w_next = COLLECT;
        end
      end
      FULL: begin
        bus.in_ready = 1'b1;
        w_set_ovf    = bus.in_valid;
        if (load_end) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_word_idx <= '0;
      r_overflow <= 1'b0;
      r_end_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_word_idx <= '0;
        r_overflow <= 1'b0;
        r_end_pend <= 1'b0;
      end else begin
        if (w_inc)      r_word_idx <= r_word_idx + 32'd1;
        if (w_set_ovf)  r_overflow <= 1'b1;
        if (w_set_pend) r_end_pend <= 1'b1;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign overflow   = r_overflow;
  assign word_count = r_word_idx;

endmodule
